// File: rtl/sjr_method_callee_if.sv
// Call/return bundle for the method test(boolean t1, short t2, int t3) returning int.
// The master is the caller and the slave is the callee.
interface sjr_method_callee_if #(
   parameter int unsigned W_T2 = 16,
   parameter int unsigned W_T3 = 32
);
   logic            test_req;
   logic            test_t1;
   logic [W_T2-1:0] test_t2;
   logic [W_T3-1:0] test_t3;
   logic            test_busy;
   logic [W_T3-1:0] test_return;
   logic [15:0]     calls_done;

   modport master (
      output test_req, test_t1, test_t2, test_t3,
      input  test_busy, test_return, calls_done
   );

   modport slave (
      input  test_req, test_t1, test_t2, test_t3,
      output test_busy, test_return, calls_done
   );
endinterface

// File: rtl/sjr_method_callee.sv
// Callee for the Synthesijer req/busy/return handshake. It computes either the low
// W_T3 bits of t2*t3 with a shift-add loop, or t3 - t2. All outputs are registered.
module sjr_method_callee #(
   parameter int unsigned W_T2 = 16,
   parameter int unsigned W_T3 = 32
) (
   input logic                clk,
   input logic                reset,
   sjr_method_callee_if.slave bus
);
   localparam int unsigned         W_CNT    = $clog2(W_T2) + 1;
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(W_T2 - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_EXEC,
      S_DONE
   } state_t;

   state_t          r_state;
   logic            r_t1;
   logic [W_T2-1:0] r_t2;
   logic [W_T3-1:0] r_t3;
   logic [W_T3-1:0] r_acc;
   logic [W_T3-1:0] r_mcand;
   logic [W_T2-1:0] r_mplier;
   logic [W_CNT-1:0] r_cnt;
   logic            r_busy;
   logic [W_T3-1:0] r_return;
   logic [15:0]     r_calls;

   logic [W_T3-1:0] w_addend;
   logic [W_T3-1:0] w_diff;

   always_comb begin
      w_addend = '0;
      if (r_mplier[0]) begin
         w_addend = r_mcand;
      end
      w_diff = r_t3 - W_T3'(r_t2);
   end

   // busy is set on acceptance and cleared on DONE->IDLE, so it tracks state != IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_t1     <= 1'b0;
         r_t2     <= '0;
         r_t3     <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_return <= '0;
         r_calls  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.test_req) begin
                  r_t1    <= bus.test_t1;
                  r_t2    <= bus.test_t2;
                  r_t3    <= bus.test_t3;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_acc    <= '0;
               r_mcand  <= r_t3;
               r_mplier <= r_t2;
               r_cnt    <= '0;
               r_state  <= S_EXEC;
            end
            S_EXEC: begin
               if (r_t1) begin
                  r_acc    <= r_acc + w_addend;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt + W_CNT'(1);
                  if (r_cnt == CNT_LAST) begin
                     r_state <= S_DONE;
                  end
               end else begin
                  r_acc   <= w_diff;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_return <= r_acc;
               r_calls  <= r_calls + 16'd1;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.test_busy   = r_busy;
   assign bus.test_return = r_return;
   assign bus.calls_done  = r_calls;

endmodule
